// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the page-decoded burst memory controller:
// bus geometry, page field position and FSM state encoding.
package mem_ctrl_pkg;

    localparam int unsigned BUSWIDTH = 16;
    localparam int unsigned BURSTLEN = 4;
    localparam int unsigned PAGE_MSB = 15;
    localparam int unsigned PAGE_LSB = 12;
    localparam int unsigned PAGE_W   = PAGE_MSB - PAGE_LSB + 1;
    localparam int unsigned CNT_W    = $clog2(BURSTLEN);

    typedef logic [BUSWIDTH-1:0] word_t;
    typedef logic [0:0]          state_t;

    localparam state_t StIdle = 1'b0;
    localparam state_t StXfer = 1'b1;

    function automatic logic [PAGE_W-1:0] page_of(input word_t a);
        return a[PAGE_MSB:PAGE_LSB];
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Memory-array port bundle: the controller is the initiator (master),
// the array is the target (slave).
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    word_t Addr;
    word_t DataIn;
    word_t DataOut;
    logic  rdEn;
    logic  wrEn;

    modport master (output Addr, output DataIn, output rdEn, output wrEn, input DataOut);
    modport slave  (input Addr, input DataIn, input rdEn, input wrEn, output DataOut);

endinterface

// File: rtl/mem_ctrl.sv
// Page-decoded burst controller: claims a BURSTLEN-word read or write from the
// shared multiplexed bus and sequences word addresses and enables to one array.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [PAGE_W-1:0] PAGE = 4'h0
) (
    input  logic               clk,
    input  logic               resetL,
    input  logic               AddrValid,
    input  logic               rw,
    inout  wire [BUSWIDTH-1:0] AddrData,
    mem_ctrl_if.master         mem
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    word_t            base_q, base_d;
    word_t            addr_q, addr_d;
    logic             rw_q, rw_d;
    logic             rd_en_q, rd_en_d;
    logic             wr_en_q, wr_en_d;
    logic             start;
    logic             xfer;

    assign start = AddrValid && (page_of(AddrData) == PAGE);
    assign xfer  = (state_q == StXfer);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        rd_en_d = rd_en_q;
        wr_en_d = wr_en_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StXfer;
                    cnt_d   = '0;
                    base_d  = AddrData;
                    addr_d  = AddrData;
                    rw_d    = rw;
                    rd_en_d = rw;
                    wr_en_d = !rw;
                end
            end
            StXfer: begin
                // A new AddrValid here is a protocol violation and is deliberately ignored.
                if (cnt_q == CNT_W'(BURSTLEN - 1)) begin
                    state_d = StIdle;
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    addr_d = base_q + BUSWIDTH'(cnt_d);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetL) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
        end
    end

    assign mem.Addr   = addr_q;
    assign mem.rdEn   = rd_en_q;
    assign mem.wrEn   = wr_en_q;
    // Read data goes straight from the array onto the bus in the same cycle.
    assign mem.DataIn = (xfer && !rw_q) ? AddrData : '0;
    assign AddrData   = (xfer && rw_q) ? mem.DataOut : 'z;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench: three controllers (pages 2, 3, F) on one shared bus, each with its own array,
// driven from a directed table, a reset sequence and random bursts against a model.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    typedef logic [3:0][15:0] burst_t;
    typedef struct {
        logic [15:0] addr;
        logic        rw;
        burst_t      d;
        logic        stray;
        burst_t      ea;
        int          owner;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetL = 1'b0;
    logic        AddrValid = 1'b0;
    logic        rw = 1'b0;
    logic        drv_en = 1'b1;
    logic [15:0] drv_val = 16'h0;
    wire  [15:0] AddrData;

    int checks = 0;
    int errors = 0;

    logic [15:0] hold [3];
    logic [15:0] mdl  [3][65536];
    logic [15:0] arr2 [65536];
    logic [15:0] arr3 [65536];
    logic [15:0] arrf [65536];
    logic [15:0] wq   [3][$];
    vec_t        vecs [12];

    assign AddrData = drv_en ? drv_val : 'z;

    mem_ctrl_if mif2 ();
    mem_ctrl_if mif3 ();
    mem_ctrl_if miff ();

    mem_ctrl #(.PAGE(4'h2)) u_p2 (.clk(clk), .resetL(resetL), .AddrValid(AddrValid), .rw(rw),
                                  .AddrData(AddrData), .mem(mif2));
    mem_ctrl #(.PAGE(4'h3)) u_p3 (.clk(clk), .resetL(resetL), .AddrValid(AddrValid), .rw(rw),
                                  .AddrData(AddrData), .mem(mif3));
    mem_ctrl #(.PAGE(4'hF)) u_pf (.clk(clk), .resetL(resetL), .AddrValid(AddrValid), .rw(rw),
                                  .AddrData(AddrData), .mem(miff));

    always #5 clk = ~clk;

    always @(posedge clk) if (mif2.wrEn) arr2[mif2.Addr] <= mif2.DataIn;
    always @(posedge clk) if (mif3.wrEn) arr3[mif3.Addr] <= mif3.DataIn;
    always @(posedge clk) if (miff.wrEn) arrf[miff.Addr] <= miff.DataIn;
    assign mif2.DataOut = arr2[mif2.Addr];
    assign mif3.DataOut = arr3[mif3.Addr];
    assign miff.DataOut = arrf[miff.Addr];

    function automatic burst_t mk4(input logic [15:0] w0, w1, w2, w3);
        return {w3, w2, w1, w0};
    endfunction

    function automatic int owner_of(input logic [15:0] a);
        case (a[15:12])
            4'h2:    return 0;
            4'h3:    return 1;
            4'hF:    return 2;
            default: return -1;
        endcase
    endfunction

    function automatic logic [15:0] o_addr(input int k);
        case (k)
            0:       return mif2.Addr;
            1:       return mif3.Addr;
            default: return miff.Addr;
        endcase
    endfunction

    function automatic logic [15:0] o_din(input int k);
        case (k)
            0:       return mif2.DataIn;
            1:       return mif3.DataIn;
            default: return miff.DataIn;
        endcase
    endfunction

    function automatic logic o_rd(input int k);
        case (k)
            0:       return mif2.rdEn;
            1:       return mif3.rdEn;
            default: return miff.rdEn;
        endcase
    endfunction

    function automatic logic o_wr(input int k);
        case (k)
            0:       return mif2.wrEn;
            1:       return mif3.wrEn;
            default: return miff.wrEn;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_inst(input string tag, input int k, input logic [15:0] ea, input logic rd,
                            input logic wr, input logic [15:0] din, input logic din_chk);
        chk($sformatf("%s p%0d Addr", tag, k), 32'(o_addr(k)), 32'(ea));
        chk($sformatf("%s p%0d rdEn", tag, k), 32'(o_rd(k)), 32'(rd));
        chk($sformatf("%s p%0d wrEn", tag, k), 32'(o_wr(k)), 32'(wr));
        if (din_chk) chk($sformatf("%s p%0d DataIn", tag, k), 32'(o_din(k)), 32'(din));
    endtask

    task automatic idle_cycle(input string tag);
        AddrValid = 1'b0;
        drv_en    = 1'b1;
        drv_val   = 16'h0;
        @(negedge clk);
        chk($sformatf("%s bus", tag), 32'(AddrData), 32'h0);
        for (int k = 0; k < 3; k++) chk_inst(tag, k, hold[k], 1'b0, 1'b0, 16'h0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // One address cycle then BURSTLEN data cycles; entered and left just after a rising edge.
    task automatic do_burst(input string tag, input logic [15:0] addr, input logic rw_i,
                            input burst_t d, input logic stray, input burst_t ea, input int owner);
        AddrValid = 1'b1;
        rw        = rw_i;
        drv_en    = 1'b1;
        drv_val   = addr;
        @(negedge clk);
        chk($sformatf("%s c0 bus", tag), 32'(AddrData), 32'(addr));
        for (int k = 0; k < 3; k++)
            chk_inst($sformatf("%s c0", tag), k, hold[k], 1'b0, 1'b0, 16'h0, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < BURSTLEN; i++) begin
            AddrValid = stray && (i == 1);
            drv_en    = !rw_i;
            drv_val   = rw_i ? 16'h0 : d[i];
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (k == owner)
                    chk_inst($sformatf("%s w%0d", tag, i), k, ea[i], rw_i, !rw_i, d[i], !rw_i);
                else
                    chk_inst($sformatf("%s w%0d", tag, i), k, hold[k], 1'b0, 1'b0, 16'h0, 1'b1);
            end
            if (owner >= 0 || !rw_i) chk($sformatf("%s w%0d bus", tag, i), 32'(AddrData), 32'(d[i]));
            @(posedge clk);
            #1;
        end
        AddrValid = 1'b0;
        drv_en    = 1'b1;
        drv_val   = 16'h0;
        if (owner >= 0) begin
            hold[owner] = ea[3];
            if (!rw_i) for (int i = 0; i < BURSTLEN; i++) mdl[owner][ea[i]] = d[i];
        end
    endtask

    initial begin
        int          k;
        int          own;
        logic        rdo;
        logic [15:0] base;
        burst_t      d;
        burst_t      ea;

        for (int m = 0; m < 3; m++) begin
            hold[m] = 16'h0;
            for (int a = 0; a < 65536; a++) mdl[m][a] = 16'h0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset bus", 32'(AddrData), 32'h0);
        for (int m = 0; m < 3; m++) chk_inst("reset", m, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        @(posedge clk);
        #1;
        resetL = 1'b1;

        vecs[0]  = '{16'h2010, 1'b0, mk4(16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3), 1'b0,
                     mk4(16'h2010, 16'h2011, 16'h2012, 16'h2013), 0};
        vecs[1]  = '{16'h2010, 1'b1, mk4(16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3), 1'b0,
                     mk4(16'h2010, 16'h2011, 16'h2012, 16'h2013), 0};
        vecs[2]  = '{16'h3010, 1'b0, mk4(16'hB0B0, 16'hB1B1, 16'hB2B2, 16'hB3B3), 1'b0,
                     mk4(16'h3010, 16'h3011, 16'h3012, 16'h3013), 1};
        vecs[3]  = '{16'h3010, 1'b1, mk4(16'hB0B0, 16'hB1B1, 16'hB2B2, 16'hB3B3), 1'b0,
                     mk4(16'h3010, 16'h3011, 16'h3012, 16'h3013), 1};
        vecs[4]  = '{16'h2FFE, 1'b0, mk4(16'hC0C0, 16'hC1C1, 16'hC2C2, 16'hC3C3), 1'b0,
                     mk4(16'h2FFE, 16'h2FFF, 16'h3000, 16'h3001), 0};
        vecs[5]  = '{16'h2FFE, 1'b1, mk4(16'hC0C0, 16'hC1C1, 16'hC2C2, 16'hC3C3), 1'b0,
                     mk4(16'h2FFE, 16'h2FFF, 16'h3000, 16'h3001), 0};
        vecs[6]  = '{16'hFFFE, 1'b0, mk4(16'hD0D0, 16'hD1D1, 16'hD2D2, 16'hD3D3), 1'b0,
                     mk4(16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001), 2};
        vecs[7]  = '{16'hFFFE, 1'b1, mk4(16'hD0D0, 16'hD1D1, 16'hD2D2, 16'hD3D3), 1'b0,
                     mk4(16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001), 2};
        vecs[8]  = '{16'h2020, 1'b0, mk4(16'hE0E0, 16'h2BB1, 16'hE2E2, 16'hE3E3), 1'b1,
                     mk4(16'h2020, 16'h2021, 16'h2022, 16'h2023), 0};
        vecs[9]  = '{16'h2020, 1'b1, mk4(16'hE0E0, 16'h2BB1, 16'hE2E2, 16'hE3E3), 1'b0,
                     mk4(16'h2020, 16'h2021, 16'h2022, 16'h2023), 0};
        vecs[10] = '{16'h5000, 1'b0, mk4(16'h5151, 16'h5252, 16'h5353, 16'h5454), 1'b0,
                     mk4(16'h0, 16'h0, 16'h0, 16'h0), -1};
        vecs[11] = '{16'h3010, 1'b1, mk4(16'hB0B0, 16'hB1B1, 16'hB2B2, 16'hB3B3), 1'b0,
                     mk4(16'h3010, 16'h3011, 16'h3012, 16'h3013), 1};

        // Back-to-back: every table entry starts in the cycle after the previous one ends.
        for (int v = 0; v < 12; v++)
            do_burst($sformatf("vec%0d", v), vecs[v].addr, vecs[v].rw, vecs[v].d, vecs[v].stray,
                     vecs[v].ea, vecs[v].owner);
        idle_cycle("post table");

        // Reset in cycle 2 of a write burst: only words 0 and 1 land.
        do_burst("rst pre", 16'h2100, 1'b0, mk4(16'hF0F0, 16'hF1F1, 16'hF2F2, 16'hF3F3), 1'b0,
                 mk4(16'h2100, 16'h2101, 16'h2102, 16'h2103), 0);
        AddrValid = 1'b1;
        rw        = 1'b0;
        drv_val   = 16'h2100;
        @(posedge clk);
        #1;
        AddrValid = 1'b0;
        drv_val   = 16'h1111;
        @(negedge clk);
        chk_inst("rst c1", 0, 16'h2100, 1'b0, 1'b1, 16'h1111, 1'b1);
        @(posedge clk);
        #1;
        resetL    = 1'b0;
        AddrValid = 1'b1;
        drv_val   = 16'h3155;
        @(negedge clk);
        chk_inst("rst c2", 0, 16'h2101, 1'b0, 1'b1, 16'h3155, 1'b1);
        @(posedge clk);
        #1;
        resetL    = 1'b1;
        AddrValid = 1'b0;
        drv_val   = 16'h0;
        for (int m = 0; m < 3; m++) hold[m] = 16'h0;
        mdl[0][16'h2100] = 16'h1111;
        mdl[0][16'h2101] = 16'h3155;
        @(negedge clk);
        chk("rst c3 bus", 32'(AddrData), 32'h0);
        for (int m = 0; m < 3; m++) chk_inst("rst c3", m, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        @(posedge clk);
        #1;
        do_burst("rst read", 16'h2100, 1'b1, mk4(16'h1111, 16'h3155, 16'hF2F2, 16'hF3F3), 1'b0,
                 mk4(16'h2100, 16'h2101, 16'h2102, 16'h2103), 0);

        // Random bursts against the model.
        for (int n = 0; n < 60; n++) begin
            k   = int'($urandom_range(0, 3));
            rdo = (k < 3) && (wq[k].size() > 0) && ($urandom_range(0, 1) == 1);
            if (rdo) begin
                base = wq[k][$urandom_range(0, wq[k].size() - 1)];
            end else begin
                base = 16'($urandom);
                case (k)
                    0:       base[15:12] = 4'h2;
                    1:       base[15:12] = 4'h3;
                    2:       base[15:12] = 4'hF;
                    default: base[15:12] = 4'($urandom_range(4, 14));
                endcase
            end
            own = owner_of(base);
            for (int i = 0; i < 4; i++) begin
                ea[i] = base + 16'(i);
                d[i]  = (rdo && own >= 0) ? mdl[own][ea[i]] : 16'($urandom);
            end
            do_burst($sformatf("rnd%0d", n), base, rdo, d, 1'b0, ea, own);
            if (!rdo && own >= 0) wq[own].push_back(base);
            repeat ($urandom_range(0, 2)) idle_cycle($sformatf("rnd%0d gap", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
